// File: rtl/oled_frame_tx_if.sv
// Pixel-plotter and OLED panel pins of the frame transmitter.
// The master side is the transmitter; the slave side is the plotter and panel.
interface oled_frame_tx_if;
    logic [15:0] pixel_data;
    logic [12:0] pixel_index;
    logic        frame_begin;
    logic        sending_pixels;
    logic        cs;
    logic        sclk;
    logic        sdin;
    logic        d_cn;
    logic        resn;
    logic        vccen;
    logic        pmoden;

    modport master (
        input  pixel_data,
        output pixel_index, frame_begin, sending_pixels,
        output cs, sclk, sdin, d_cn, resn, vccen, pmoden
    );

    modport slave (
        output pixel_data,
        input  pixel_index, frame_begin, sending_pixels,
        input  cs, sclk, sdin, d_cn, resn, vccen, pmoden
    );
endinterface

// File: rtl/oled_frame_tx.sv
// SPI transmitter for a 96x64 RGB565 OLED: power-up, fixed init commands, then
// continuous MSB-first pixel streaming fed by a combinational plotter.
module oled_frame_tx #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned RST_CYCLES = 1000,
    parameter int unsigned WIDTH      = 96,
    parameter int unsigned HEIGHT     = 64
) (
    input  logic            CLOCK,
    input  logic            RESET,
    oled_frame_tx_if.master oled
);
    localparam int unsigned DIV_W    = $clog2(CLK_DIV);
    localparam int unsigned RST_W    = $clog2(RST_CYCLES + 1);
    localparam int unsigned PIX_LAST = WIDTH * HEIGHT - 1;

    typedef enum logic [1:0] {StRstLow, StRstWait, StInit, StStream} state_e;

    state_e           r_state, w_state_d;
    logic [RST_W-1:0] r_rst_cnt;
    logic [DIV_W-1:0] r_div;
    logic [3:0]       r_bit;
    logic [1:0]       r_cmd_idx;
    logic [15:0]      r_shift;
    logic [12:0]      r_pix_idx;
    logic             r_sclk;
    logic             r_pmoden;
    logic             r_frame_begin;
    logic             w_active;
    logic             w_bit_end;
    logic             w_unit_end;
    logic             w_enter_init;
    logic [7:0]       w_cmd_next;

    always_comb begin
        w_active   = (r_state == StInit) || (r_state == StStream);
        w_bit_end  = w_active && r_sclk && (r_div == DIV_W'(CLK_DIV - 1));
        w_unit_end = w_bit_end && (r_bit == ((r_state == StInit) ? 4'd7 : 4'd15));
        unique case (r_cmd_idx)
            2'd0:    w_cmd_next = 8'hA0;
            2'd1:    w_cmd_next = 8'h72;
            default: w_cmd_next = 8'hAF;
        endcase
    end

    // RST_LOW also spans the reset-held period, so it waits one extra count
    // to give RST_CYCLES clocks with pmoden high after release.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StRstLow:  if (r_rst_cnt == RST_W'(RST_CYCLES)) w_state_d = StRstWait;
            StRstWait: if (r_rst_cnt == RST_W'(RST_CYCLES - 1)) w_state_d = StInit;
            StInit:    if (w_unit_end && (r_cmd_idx == 2'd3)) w_state_d = StStream;
            default:   w_state_d = StStream;
        endcase
        w_enter_init = (r_state == StRstWait) && (w_state_d == StInit);
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) r_state <= StRstLow;
        else       r_state <= w_state_d;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_rst_cnt     <= '0;
            r_div         <= '0;
            r_bit         <= '0;
            r_cmd_idx     <= '0;
            r_shift       <= '0;
            r_pix_idx     <= '0;
            r_sclk        <= 1'b1;
            r_pmoden      <= 1'b0;
            r_frame_begin <= 1'b0;
        end else begin
            r_pmoden      <= 1'b1;
            r_frame_begin <= 1'b0;
            if (r_state != w_state_d) r_rst_cnt <= '0;
            else if (!w_active)       r_rst_cnt <= r_rst_cnt + 1'b1;

            if (w_enter_init) begin
                r_sclk    <= 1'b0;
                r_div     <= '0;
                r_bit     <= '0;
                r_cmd_idx <= '0;
                r_shift   <= {8'hAE, 8'h00};
            end else if (w_active) begin
                if (r_div != DIV_W'(CLK_DIV - 1)) begin
                    r_div <= r_div + 1'b1;
                end else begin
                    r_div <= '0;
                    if (!r_sclk) begin
                        r_sclk <= 1'b1;
                    end else begin
                        // End of a bit period: sclk falls and the next bit starts.
                        r_sclk <= 1'b0;
                        if (w_unit_end) begin
                            r_bit <= '0;
                            if ((r_state == StInit) && (r_cmd_idx != 2'd3)) begin
                                r_cmd_idx <= r_cmd_idx + 1'b1;
                                r_shift   <= {w_cmd_next, 8'h00};
                            end else begin
                                r_shift       <= oled.pixel_data;
                                r_frame_begin <= (r_state == StInit);
                            end
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= {r_shift[14:0], 1'b0};
                            // Advance as the last pixel bit starts to give the plotter settle time.
                            if ((r_state == StStream) && (r_bit == 4'd14)) begin
                                if (r_pix_idx == 13'(PIX_LAST)) begin
                                    r_pix_idx     <= '0;
                                    r_frame_begin <= 1'b1;
                                end else begin
                                    r_pix_idx <= r_pix_idx + 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    assign oled.cs             = !w_active;
    assign oled.sclk           = r_sclk;
    assign oled.sdin           = r_shift[15];
    assign oled.d_cn           = (r_state == StStream);
    assign oled.resn           = (r_state != StRstLow);
    assign oled.vccen          = w_active;
    assign oled.pmoden         = r_pmoden;
    assign oled.pixel_index    = r_pix_idx;
    assign oled.frame_begin    = r_frame_begin;
    assign oled.sending_pixels = (r_state == StStream);
endmodule

// File: tb/tb_oled_frame_tx.sv
// Self-checking bench for oled_frame_tx: power-up table, SPI scoreboard,
// frame wrap, pixel_data stability and mid-word reset.
module tb_oled_frame_tx;
    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned RST_CYC = 4;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned HEIGHT  = 4;
    localparam int unsigned NPIX    = WIDTH * HEIGHT;
    localparam int          MASK    = 16383;

    typedef struct packed {
        logic        dcn;
        logic [15:0] data;
    } unit_t;

    typedef struct {
        int unsigned edge_n;
        logic [6:0]  exp;  // {pmoden, resn, cs, vccen, d_cn, sclk, sdin}
    } rvec_t;

    logic CLOCK;
    logic RESET;
    logic noisy;
    logic [15:0] noise16;
    logic [15:0] hist [0:MASK];
    unit_t q [$];
    int n_chk = 0;
    int n_fail = 0;
    int n_noisy = 0;
    int fb_cnt = 0;
    int cyc = 0;

    oled_frame_tx_if bus ();

    oled_frame_tx #(
        .CLK_DIV    (CLK_DIV),
        .RST_CYCLES (RST_CYC),
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT)
    ) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .oled  (bus.master)
    );

    assign bus.pixel_data = noisy ? noise16 : {3'b000, bus.pixel_index};

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [21:0] out_vec();
        return {bus.cs, bus.sclk, bus.sdin, bus.d_cn, bus.resn, bus.vccen, bus.pmoden,
                bus.frame_begin, bus.sending_pixels, bus.pixel_index};
    endfunction

    function automatic logic [6:0] pin_vec();
        return {bus.pmoden, bus.resn, bus.cs, bus.vccen, bus.d_cn, bus.sclk, bus.sdin};
    endfunction

    task automatic push_cmds();
        q.push_back('{dcn: 1'b0, data: 16'h00AE});
        q.push_back('{dcn: 1'b0, data: 16'h00A0});
        q.push_back('{dcn: 1'b0, data: 16'h0072});
        q.push_back('{dcn: 1'b0, data: 16'h00AF});
    endtask

    // SPI monitor, pixel-index/frame_begin checker and pixel_data noise source.
    logic [15:0] shreg;
    int          nbits;
    int          unit_len;
    int          last_len;
    int          last_rise;
    int          unit_rise;
    logic        unit_dcn;
    logic        prev_sclk;
    logic        prev_send;
    logic [12:0] prev_idx;
    logic        exp_fb;
    logic [15:0] got;
    logic [31:0] rnd;
    unit_t       e;

    always @(negedge CLOCK) begin
        cyc++;
        if (RESET) begin
            nbits = 0;
            last_rise = -1;
            prev_sclk = 1'b1;
            prev_send = 1'b0;
            prev_idx = '0;
        end else begin
            if (bus.sending_pixels) begin
                exp_fb = (bus.pixel_index == 13'd0) && (!prev_send || (prev_idx != 13'd0));
                chk("frame_begin", 32'(bus.frame_begin), 32'(exp_fb));
                if (bus.frame_begin) fb_cnt++;
                if (prev_send && (bus.pixel_index != prev_idx)) begin
                    chk("idx_step", 32'(bus.pixel_index),
                        (32'(prev_idx) == NPIX - 1) ? 32'd0 : 32'(prev_idx) + 32'd1);
                    chk("idx_timing", {prev_sclk, bus.sclk, 30'(nbits)}, {1'b1, 1'b0, 30'd15});
                end
            end else begin
                chk("idle_idx", {18'd0, bus.frame_begin, bus.pixel_index}, 32'd0);
            end

            if (!bus.cs && bus.sclk && !prev_sclk) begin
                if (nbits == 0) begin
                    unit_dcn = bus.d_cn;
                    unit_len = bus.d_cn ? 16 : 8;
                    if (last_rise >= 0)
                        chk("unit_period", 32'(cyc - last_rise), 32'(last_len * 2 * CLK_DIV));
                    last_rise = cyc;
                    last_len = unit_len;
                    unit_rise = cyc;
                end
                shreg = {shreg[14:0], bus.sdin};
                nbits++;
                if (nbits == unit_len) begin
                    nbits = 0;
                    got = (unit_len == 8) ? {8'h00, shreg[7:0]} : shreg;
                    if (unit_dcn && noisy) begin
                        chk("noisy_word", 32'(got), 32'(hist[(unit_rise - CLK_DIV - 1) & MASK]));
                        n_noisy++;
                    end else if (q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_unit: got %0h with d_cn=%0b, none expected",
                                 got, unit_dcn);
                    end else begin
                        e = q.pop_front();
                        chk("spi_unit", 32'({unit_dcn, got}), 32'({e.dcn, e.data}));
                    end
                end
            end
            prev_sclk = bus.sclk;
            prev_send = bus.sending_pixels;
            prev_idx = bus.pixel_index;
        end
        rnd = $urandom;
        noise16 = rnd[15:0];
        hist[cyc & MASK] = noise16;
    end

    rvec_t       rtab [8];
    logic [21:0] rst_vec;
    int unsigned cur_edge;

    initial begin
        rtab[0] = '{edge_n: 0,  exp: 7'b0010010};
        rtab[1] = '{edge_n: 1,  exp: 7'b1010010};
        rtab[2] = '{edge_n: 4,  exp: 7'b1010010};
        rtab[3] = '{edge_n: 5,  exp: 7'b1110010};
        rtab[4] = '{edge_n: 8,  exp: 7'b1110010};
        rtab[5] = '{edge_n: 9,  exp: 7'b1101001};
        rtab[6] = '{edge_n: 11, exp: 7'b1101011};
        rtab[7] = '{edge_n: 13, exp: 7'b1101000};
        rst_vec = {1'b1, 1'b1, 20'd0};
        noise16 = '0;

        // Reset held with pixel_data toggling every clock.
        RESET = 1'b1;
        noisy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLOCK);
            #1 chk("reset_outputs", 32'(out_vec()), 32'(rst_vec));
        end

        noisy = 1'b0;
        push_cmds();
        for (int k = 0; k < NPIX + 4; k++)
            q.push_back('{dcn: 1'b1, data: 16'(k % NPIX)});

        @(negedge CLOCK);
        #2 RESET = 1'b0;
        cur_edge = 0;
        for (int i = 0; i < 8; i++) begin
            while (cur_edge < rtab[i].edge_n) begin
                @(posedge CLOCK);
                cur_edge++;
            end
            #1 chk($sformatf("powerup_e%0d", rtab[i].edge_n), 32'(pin_vec()), 32'(rtab[i].exp));
        end

        for (int t = 0; t < 6000 && q.size() != 0; t++) @(negedge CLOCK);
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("frame_begin_pulses", 32'(fb_cnt), 32'd2);

        // Abort a pixel word mid-flight.
        repeat (30) @(negedge CLOCK);
        chk("stream_before_reset", 32'(bus.sending_pixels), 32'd1);
        #2 RESET = 1'b1;
        q.delete();
        #1 chk("midword_reset", 32'(out_vec()), 32'(rst_vec));
        repeat (3) @(negedge CLOCK);
        #1 chk("reset_hold", 32'(out_vec()), 32'(rst_vec));

        // Re-init, then stream words while pixel_data changes every clock.
        noisy = 1'b1;
        n_noisy = 0;
        push_cmds();
        @(negedge CLOCK);
        #2 RESET = 1'b0;
        for (int t = 0; t < 3000 && n_noisy < 4; t++) @(negedge CLOCK);
        chk("noisy_words_seen", 32'(n_noisy >= 4), 32'd1);
        chk("reinit_cmds_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
